instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of decode and immediate generation. Holds the PC, issues word requests to instruction memory, and buffers in-order responses in a QDEPTH-entry FIFO. Presents {pc, instruction} pairs to decode over a valid/ready handshake. Handles control-flow redirects by flushing buffered words and discarding responses still in flight.

---
 rtl/instr_fetch_if.sv | 34 +++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory request/response channel, the redirect
// input and the decode-side valid/ready channel of the fetch stage.
//
// Handshake rule for both valid/ready pairs: a transfer happens on a rising
// edge where valid and ready are both high. The sender keeps valid and its
// payload stable until that edge. The memory response channel has no ready:
// a word is taken on every edge where imem_resp_valid is high.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  // Fetch-stage side.
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, if_ready
  );

  // Environment side: instruction memory, branch unit and decode.
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Keeps the fetch PC, issues word requests while
// credits remain (in-flight plus buffered words below QDEPTH), tags in-order
// responses with their PC into a small FIFO and hands {pc, instr} to decode.
// A redirect flushes the FIFO and counts the in-flight responses that must
// be dropped when they arrive.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int PW = $clog2(QDEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(QDEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [QDEPTH];
  logic [31:0]   pc_mem_q    [QDEPTH];

  logic          req_fire;
  logic          resp_push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_aligned;
  logic          unused_redirect_lsbs;

  // The low two bits of a redirect target are ignored: fetch is word aligned.
  assign redirect_aligned     = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // Request credit uses only registered counters, so there is no path from
  // if_ready or imem_resp_valid to imem_req_valid.
  assign credit_used        = {1'b0, inflight_q} + {1'b0, count_q};
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (credit_used < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc_q;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign pop       = (count_q != '0) && bus.if_ready && !bus.redirect_valid;
  assign resp_push = bus.imem_resp_valid && (discard_q == '0) && !bus.redirect_valid;

  // Decode sees the FIFO head straight from registered storage and pointer.
  assign bus.if_valid = (count_q != '0);
  assign bus.if_instr = instr_mem_q[rd_ptr_q];
  assign bus.if_pc    = pc_mem_q[rd_ptr_q];

  // Next-state for PCs, credit counters and FIFO pointers; redirect wins.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect_valid) begin
      // No request can fire this cycle; a response arriving now is dropped
      // here, every other outstanding response is dropped on arrival.
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      inflight_d = inflight_q - CW'(bus.imem_resp_valid);
      discard_d  = inflight_q - CW'(bus.imem_resp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
      if (bus.imem_resp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (resp_push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(resp_push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (resp_push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: straight-line fetch, decode backpressure,
// redirects (with stale words in flight, coinciding with a response and a
// pop, misaligned target) and a mid-run reset. Memory returns data = addr.
module tb_instr_fetch;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int cyc       = 0;
  int lat       = 1;
  int req_count = 0;
  int n_assert  = 0;
  int n_fail    = 0;

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check any pop against the expected queue, record a
  // request handshake, advance the edge, then drive the memory response.
  task automatic step();
    logic  fire;
    mreq_t m;
    logic [31:0] e;
    #1;
    fire = bus.imem_req_valid && bus.imem_req_ready;
    if (rst_n && bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
      chk("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.if_pc, e);
        chk("sb_instr", bus.if_instr, e);
      end
    end
    if (fire) begin
      req_count++;
      m.addr = bus.imem_req_addr;
      m.due  = cyc + lat;
      mem_q.push_back(m);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) mem_q.delete();
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      m = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = m.addr;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc   = 0;
    exp_q.delete();
  endtask

  initial begin
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.if_ready        = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);

    // Straight line, one-cycle memory, decode always ready
    rst_n = 1'b1;
    cyc   = 0;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("sl_req_valid", bus.imem_req_valid, 1'b1);
      chk("sl_req_addr", bus.imem_req_addr, 32'(i * 4));
      if (i >= 2) chk("sl_if_valid", bus.if_valid, 1'b1);
      step();
    end
    chk("sl_drain", exp_q.size(), 32'd0);

    // Backpressure for 10 cycles: buffer fills, requests stop
    bus.if_ready = 1'b0;
    req_count = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_if_valid", bus.if_valid, 1'b1);
      chk("bp_if_pc", bus.if_pc, 32'd32);
      chk("bp_if_instr", bus.if_instr, 32'd32);
      if (i >= 2) chk("bp_req_stop", bus.imem_req_valid, 1'b0);
      step();
    end
    chk("bp_req_count", req_count, 32'd2);
    bus.if_ready = 1'b1;
    for (int i = 8; i < 16; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 8; i++) step();
    chk("bp_drain", exp_q.size(), 32'd0);

    // Redirect with two requests in flight, three-cycle memory
    lat = 3;
    do_reset();
    bus.if_ready = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C);
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk("rd_req_gated", bus.imem_req_valid, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd_flushed", bus.if_valid, 1'b0);
    chk("rd_req_valid", bus.imem_req_valid, 1'b1);
    chk("rd_req_addr", bus.imem_req_addr, 32'h100);
    step();
    chk("rd_addr_next", bus.imem_req_addr, 32'h104);
    for (int i = 0; i < 3; i++) begin
      chk("rd_no_stale", bus.if_valid, 1'b0);
      step();
    end
    chk("rd_target_valid", bus.if_valid, 1'b1);
    chk("rd_target_pc", bus.if_pc, 32'h100);
    for (int i = 0; i < 4; i++) step();
    chk("rd_drain", exp_q.size(), 32'd0);

    // Misaligned redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    bus.if_ready = 1'b1;
    exp_q.push_back(32'h0);
    step();
    step();
    step();
    chk("rc_head_pc", bus.if_pc, 32'h4);
    chk("rc_head_valid", bus.if_valid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    #1;
    chk("rc_req_gated", bus.imem_req_valid, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rc_flushed", bus.if_valid, 1'b0);
    chk("rc_req_addr", bus.imem_req_addr, 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    step();
    step();
    chk("rc_target_pc", bus.if_pc, 32'h200);
    chk("rc_target_instr", bus.if_instr, 32'h200);
    for (int i = 0; i < 3; i++) step();
    chk("rc_drain", exp_q.size(), 32'd0);

    // Mid-run reset with a buffered word and two requests in flight
    lat = 2;
    do_reset();
    step();
    step();
    step();
    chk("mr_pre_valid", bus.if_valid, 1'b1);
    chk("mr_pre_pc", bus.if_pc, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lat = 1;
    #1;
    chk("mr_if_valid", bus.if_valid, 1'b0);
    chk("mr_if_instr", bus.if_instr, 32'h0);
    chk("mr_req_valid", bus.imem_req_valid, 1'b1);
    bus.imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mr_stall_addr", bus.imem_req_addr, 32'h0);
      chk("mr_stall_valid", bus.imem_req_valid, 1'b1);
      step();
    end
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int i = 0; i < 5; i++) step();
    chk("mr_drain", exp_q.size(), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
